// File: rtl/random_word_packer_if.sv
// rtl/random_word_packer_if.sv - bit stream in / word stream out handshake bundle
// Ports (slave = packer side):
//   bit_in, bit_valid   serial random bits into the packer
//   word_out            head word of the packer FIFO, 0 while word_valid is low
//   word_valid          packer FIFO not empty
//   word_ready          consumer takes the head word on word_valid & word_ready
interface random_word_packer_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  word_ready,
        output word_out,
        output word_valid
    );

    modport master (
        output bit_in,
        output bit_valid,
        output word_ready,
        input  word_out,
        input  word_valid
    );
endinterface

// File: rtl/random_word_packer.sv
// rtl/random_word_packer.sv - packs serial random bits into range-limited words with FIFO
// Ports:
//   qzt_clk        system clock, rising edge
//   rst_n          asynchronous active-low reset
//   clear          synchronous clear of rejected_cnt and overflow
//   io             bit stream in, word stream out (random_word_packer_if.slave)
//   fifo_level     number of stored words, 0..DEPTH
//   rejected_cnt   saturating count of words >= LIMIT
//   overflow       sticky: an accepted word was lost to a full FIFO
module random_word_packer #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 200,
    parameter int DEPTH = 4
) (
    input  logic                     qzt_clk,
    input  logic                     rst_n,
    input  logic                     clear,
    random_word_packer_if.slave      io,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              rejected_cnt,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    // One extra bit so LIMIT = 2^WIDTH is representable and accepts every word.
    localparam logic [WIDTH:0] LIMIT_W  = (WIDTH + 1)'(LIMIT);
    localparam logic [AW:0]    DEPTH_W  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] cand;
    logic             cand_v;
    logic [WIDTH-1:0] next_word;
    logic             last_bit;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level;
    logic             empty;
    logic             full;
    logic             pop;
    logic             in_range;
    logic             push;
    logic             lost;
    logic             reject;

    assign next_word = {shreg[WIDTH-2:0], io.bit_in};
    assign last_bit  = io.bit_valid && (bit_cnt == LAST_BIT);

    // Assembly and candidate stage; the candidate register never stalls.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            cand    <= '0;
            cand_v  <= 1'b0;
        end else begin
            cand_v <= last_bit;
            if (io.bit_valid) begin
                shreg   <= next_word;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            if (last_bit) begin
                cand <= next_word;
            end
        end
    end

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (level == DEPTH_W);
    assign pop      = !empty && io.word_ready;
    assign in_range = ({1'b0, cand} < LIMIT_W);
    // A pop on the decision edge frees the slot the new word needs.
    assign push     = cand_v && in_range && (!full || pop);
    assign lost     = cand_v && in_range && full && !pop;
    assign reject   = cand_v && !in_range;

    // Storage is not reset; word_out is gated by empty instead.
    always_ff @(posedge qzt_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cand;
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            rejected_cnt <= '0;
            overflow     <= 1'b0;
        end else if (clear) begin
            rejected_cnt <= '0;
            overflow     <= 1'b0;
        end else begin
            if (reject && (rejected_cnt != 16'hFFFF)) begin
                rejected_cnt <= rejected_cnt + 16'd1;
            end
            if (lost) begin
                overflow <= 1'b1;
            end
        end
    end

    assign io.word_valid = !empty;
    assign io.word_out   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fifo_level    = level;
endmodule

// File: tb/tb_random_word_packer.sv
// tb/tb_random_word_packer.sv - scoreboard bench for random_word_packer
module tb_random_word_packer;
    localparam int WIDTH = 8;
    localparam int LIMIT = 200;
    localparam int DEPTH = 4;

    logic                   qzt_clk = 1'b0;
    logic                   rst_n;
    logic                   clear;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0]            rejected_cnt;
    logic                   overflow;

    random_word_packer_if #(.WIDTH(WIDTH)) io ();

    random_word_packer #(
        .WIDTH(WIDTH),
        .LIMIT(LIMIT),
        .DEPTH(DEPTH)
    ) dut (
        .qzt_clk      (qzt_clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .io           (io.slave),
        .fifo_level   (fifo_level),
        .rejected_cnt (rejected_cnt),
        .overflow     (overflow)
    );

    always #5 qzt_clk = ~qzt_clk;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               exp_rej = 0;
    logic             exp_ovf = 1'b0;
    logic [30:0]      lfsr = 31'h1234567;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are checked at the falling edge, then inputs for the next rising edge are applied.
    task automatic cycle(input logic bv, input logic b, input logic rdy);
        check("level_bound", 32'(fifo_level <= DEPTH), 32'd1);
        if (rdy && (io.word_valid === 1'b1)) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("pop_word", 32'(io.word_out), 32'(exp_q.pop_front()));
            end
        end
        io.bit_valid  = bv;
        io.bit_in     = b;
        io.word_ready = rdy;
        @(negedge qzt_clk);
        io.bit_valid  = 1'b0;
        io.word_ready = 1'b0;
    endtask

    task automatic model_word(input logic [WIDTH-1:0] w);
        if (w >= LIMIT) begin
            if (exp_rej != 32'hFFFF) exp_rej++;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int max_gap, input bit rand_rdy,
                             input bit pop_on_decision);
        int g;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) cycle(1'b0, 1'b0, rand_rdy ? 1'($urandom_range(1, 0)) : 1'b0);
            cycle(1'b1, w[i], rand_rdy ? 1'($urandom_range(1, 0)) : 1'b0);
        end
        if (pop_on_decision) cycle(1'b0, 1'b0, 1'b1);
        model_word(w);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        check({tag, "_valid"}, 32'(io.word_valid), 32'd1);
        if ((io.word_valid !== 1'b1) && (exp_q.size() != 0)) void'(exp_q.pop_front());
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic lfsr_word(output logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) begin
            w    = {w[WIDTH-2:0], lfsr[30]};
            lfsr = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
        end
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        rst_n         = 1'b0;
        clear         = 1'b0;
        io.bit_in     = 1'b0;
        io.bit_valid  = 1'b0;
        io.word_ready = 1'b0;
        repeat (2) @(negedge qzt_clk);
        check("rst_word", 32'(io.word_out), 32'd0);
        check("rst_valid", 32'(io.word_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_rej", 32'(rejected_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // MSB-first packing, two-edge latency
        send_word(8'hB2, 0, 1'b0, 1'b0);
        check("b2_latency", 32'(io.word_valid), 32'd0);
        idle();
        check("b2_valid", 32'(io.word_valid), 32'd1);
        check("b2_word", 32'(io.word_out), 32'hB2);
        check("b2_level", 32'(fifo_level), 32'd1);
        pop("b2_pop");
        check("b2_empty", 32'(fifo_level), 32'd0);
        check("b2_gated", 32'(io.word_out), 32'd0);

        // Rejection boundary
        send_word(8'hC8, 0, 1'b0, 1'b0);
        idle();
        check("c8_level", 32'(fifo_level), 32'd0);
        check("c8_rej", 32'(rejected_cnt), exp_rej);
        send_word(8'hC7, 0, 1'b0, 1'b0);
        idle();
        check("c7_word", 32'(io.word_out), 32'hC7);
        pop("c7_pop");

        // Saturation of rejected_cnt
        force dut.rejected_cnt = 16'hFFFF;
        #1;
        release dut.rejected_cnt;
        exp_rej = 32'hFFFF;
        send_word(8'hFF, 0, 1'b0, 1'b0);
        idle();
        check("rej_sat", 32'(rejected_cnt), exp_rej);
        clear = 1'b1;
        idle();
        clear   = 1'b0;
        exp_rej = 0;
        check("rej_clear", 32'(rejected_cnt), exp_rej);

        // Overflow and clear
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0);
        send_word(8'hF0, 0, 1'b0, 1'b0);
        send_word(8'h33, 0, 1'b0, 1'b0);
        send_word(8'h44, 0, 1'b0, 1'b0);
        send_word(8'h55, 0, 1'b0, 1'b0);
        idle();
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_set", 32'(overflow), 32'(exp_ovf));
        check("ovf_rej", 32'(rejected_cnt), exp_rej);
        clear = 1'b1;
        idle();
        clear   = 1'b0;
        exp_ovf = 1'b0;
        exp_rej = 0;
        check("clr_ovf", 32'(overflow), 32'(exp_ovf));
        check("clr_rej", 32'(rejected_cnt), exp_rej);
        check("clr_level", 32'(fifo_level), 32'd4);
        check("clr_head", 32'(io.word_out), 32'h11);
        repeat (4) pop("ovf_pop");
        check("ovf_drained", 32'(fifo_level), 32'd0);

        // Full FIFO with pop on the decision edge
        send_word(8'h01, 0, 1'b0, 1'b0);
        send_word(8'h02, 0, 1'b0, 1'b0);
        send_word(8'h03, 0, 1'b0, 1'b0);
        send_word(8'h04, 0, 1'b0, 1'b0);
        idle();
        check("full_level", 32'(fifo_level), 32'd4);
        send_word(8'h05, 0, 1'b0, 1'b1);
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_no_ovf", 32'(overflow), 32'd0);
        repeat (4) pop("pp_pop");

        // Asynchronous reset mid-word
        send_word(8'h10, 0, 1'b0, 1'b0);
        send_word(8'hFA, 0, 1'b0, 1'b0);
        idle();
        repeat (5) cycle(1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_rej = 0;
        exp_ovf = 1'b0;
        check("mid_rst_word", 32'(io.word_out), 32'd0);
        check("mid_rst_valid", 32'(io.word_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_rej", 32'(rejected_cnt), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge qzt_clk);
        rst_n = 1'b1;
        send_word(8'h3C, 0, 1'b0, 1'b0);
        idle();
        check("post_rst_word", 32'(io.word_out), 32'h3C);
        check("post_rst_level", 32'(fifo_level), 32'd1);
        pop("post_rst_pop");

        // Sparse bit_valid
        send_word(8'h5A, 3, 1'b0, 1'b0);
        idle();
        check("sparse_word", 32'(io.word_out), 32'h5A);
        pop("sparse_pop");

        // LFSR-driven run with random gaps and random consumer stalls
        repeat (40) begin
            lfsr_word(w);
            send_word(w, 3, 1'b1, 1'b0);
        end
        repeat (DEPTH + 4) cycle(1'b0, 1'b0, 1'b1);
        check("rand_sb_drained", 32'(exp_q.size()), 32'd0);
        check("rand_valid", 32'(io.word_valid), 32'd0);
        check("rand_rej", 32'(rejected_cnt), exp_rej);
        check("rand_ovf", 32'(overflow), 32'(exp_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
